// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: one press request becomes a bounced press,
// a stable low hold and a bounced release on an active-low key line.
module key_bounce_gen #(
  parameter logic [19:0] BOUNCE_MAX = 20'd199_999,
  parameter logic [23:0] HOLD_MAX   = 24'd2_499_999,
  parameter int          TOGGLE_W   = 12,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic press_req,
  output logic key_out,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE,
    P_BOUNCE,
    HOLD,
    R_BOUNCE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0]         lfsr;
  logic [15:0]         lfsr_nx;
  logic [19:0]         bnc_cnt;
  logic [19:0]         bnc_nx;
  logic [23:0]         hold_cnt;
  logic [23:0]         hold_nx;
  logic [TOGGLE_W-1:0] tog_cnt;
  logic [TOGGLE_W-1:0] tog_nx;
  logic                key_nx;
  logic                busy_nx;
  logic                done_nx;
  logic                start;
  logic                bnc_end;
  logic                hold_end;
  logic                tog_hit;

  // Galois form, mask 16'hB400; free-running so every burst differs
  assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400)
                           : (lfsr >> 1);

  // The done cycle is already IDLE, so a request there is masked
  assign start    = press_req && !done;
  assign bnc_end  = (bnc_cnt == BOUNCE_MAX);
  assign hold_end = (hold_cnt == HOLD_MAX);
  assign tog_hit  = (tog_cnt == '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start)    state_nx = P_BOUNCE;
      P_BOUNCE: if (bnc_end)  state_nx = HOLD;
      HOLD:     if (hold_end) state_nx = R_BOUNCE;
      R_BOUNCE: if (bnc_end)  state_nx = IDLE;
    endcase
  end

  always_comb begin
    key_nx  = key_out;
    busy_nx = busy;
    done_nx = 1'b0;
    bnc_nx  = bnc_cnt;
    hold_nx = hold_cnt;
    tog_nx  = tog_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          key_nx  = 1'b0;
          busy_nx = 1'b1;
          bnc_nx  = '0;
          tog_nx  = lfsr[TOGGLE_W-1:0];
        end
      end
      P_BOUNCE, R_BOUNCE: begin
        if (bnc_end) begin
          // Forced settle value wins over a toggle due this cycle
          key_nx = (state == R_BOUNCE);
          if (state == P_BOUNCE) begin
            hold_nx = '0;
          end else begin
            busy_nx = 1'b0;
            done_nx = 1'b1;
          end
        end else begin
          bnc_nx = bnc_cnt + 20'd1;
          if (tog_hit) begin
            key_nx = !key_out;
            tog_nx = lfsr[TOGGLE_W-1:0];
          end else begin
            tog_nx = tog_cnt - TOGGLE_W'(1);
          end
        end
      end
      HOLD: begin
        if (hold_end) begin
          key_nx = 1'b1;
          bnc_nx = '0;
          tog_nx = lfsr[TOGGLE_W-1:0];
        end else begin
          hold_nx = hold_cnt + 24'd1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lfsr     <= LFSR_SEED;
      bnc_cnt  <= '0;
      hold_cnt <= '0;
      tog_cnt  <= '0;
      key_out  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      lfsr     <= lfsr_nx;
      bnc_cnt  <= bnc_nx;
      hold_cnt <= hold_nx;
      tog_cnt  <= tog_nx;
      key_out  <= key_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule
